// File: rtl/seq_detect_param.sv
// Programmable Mealy serial-pattern detector with KMP fallback, optional overlapping
// matches, run-time pattern/length loading and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned      MAX_W   = 8,
    parameter int unsigned      LEN_W   = 4,
    parameter logic [MAX_W-1:0] DEF_PAT = 8'h0A,
    parameter int unsigned      DEF_LEN = 4,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap_en,
    input  logic             cfg_we,
    input  logic [MAX_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cnt_clr,
    output logic             flag,
    output logic             flag_q,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] k_q;
    logic [MAX_W-2:0] hist_q;

    logic [MAX_W-1:0] s_vec;
    logic [LEN_W-1:0] fb_len;
    logic             cand_ok;
    logic             hit;
    logic             cfg_legal;
    int               k_i;
    int               len_i;

    // A bit is accepted only when valid and not displaced by a config write.
    assign hit       = din_valid && !cfg_we
                       && (k_q == (len_q - LEN_W'(1)))
                       && (din == pattern_q[0]);
    assign flag      = rst_n && hit;
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_W));

    // Longest suffix of (last k bits, din) that is a proper prefix of the pattern.
    // On a full match this is the pattern's longest proper border.
    always_comb begin
        s_vec   = {hist_q, din};
        fb_len  = '0;
        cand_ok = 1'b0;
        k_i     = 32'(k_q);
        len_i   = 32'(len_q);
        for (int j = 1; j < int'(MAX_W); j++) begin
            cand_ok = (j <= k_i + 1) && (j < len_i);
            for (int i = 0; i < int'(MAX_W); i++) begin
                if (cand_ok && (i < j)) begin
                    if (s_vec[IDX_W'(i)] != pattern_q[IDX_W'(len_i - j + i)]) begin
                        cand_ok = 1'b0;
                    end
                end
            end
            if (cand_ok) begin
                fb_len = LEN_W'(j);
            end
        end
    end

    // Pattern configuration, match progress and bit history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= DEF_PAT;
            len_q     <= LEN_W'(DEF_LEN);
            k_q       <= '0;
            hist_q    <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_legal;
            if (cfg_we) begin
                if (cfg_legal) begin
                    pattern_q <= cfg_pattern;
                    len_q     <= cfg_len;
                    k_q       <= '0;
                    hist_q    <= '0;
                end
            end else if (din_valid) begin
                hist_q <= s_vec[MAX_W-2:0];
                if (hit && !overlap_en) begin
                    k_q <= '0;
                end else begin
                    k_q <= fb_len;
                end
            end
        end
    end

    // Registered flag and saturating match counter (clear applies before count).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q    <= 1'b0;
            match_cnt <= '0;
        end else begin
            flag_q <= flag;
            if (cnt_clr) begin
                match_cnt <= flag ? CNT_W'(1) : '0;
            end else if (flag && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus randomized traffic against a
// stream-level reference model (match = last len bits since restart equal the pattern).
module tb_seq_detect_param;

    localparam int unsigned MAX_W = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             overlap_en = 1'b1;
    logic             cfg_we = 1'b0;
    logic [MAX_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cnt_clr = 1'b0;
    logic             flag, flag_q, cfg_err;
    logic [CNT_W-1:0] match_cnt;
    logic             flag_s, flag_q_s, cfg_err_s;
    logic [1:0]       match_cnt_s;

    int   checks = 0;
    int   failures = 0;

    logic [7:0] m_pat;
    int         m_len;
    logic       m_q[$];
    int         m_cnt, m_cnt_s;
    logic       m_flag_q, m_err;
    logic       exp_flag, obs_flag, obs_flag_s;
    logic       ov_r = 1'b1;

    always #5 clk = ~clk;

    seq_detect_param u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .overlap_en(overlap_en), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cnt_clr(cnt_clr), .flag(flag), .flag_q(flag_q),
        .cfg_err(cfg_err), .match_cnt(match_cnt)
    );

    seq_detect_param #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .overlap_en(overlap_en), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cnt_clr(cnt_clr), .flag(flag_s), .flag_q(flag_q_s),
        .cfg_err(cfg_err_s), .match_cnt(match_cnt_s)
    );

    // True when the bits accepted since the last restart, followed by d, end in the pattern.
    function automatic logic model_hit(input logic d);
        logic b;
        if (m_q.size() < m_len - 1) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            b = (i == 0) ? d : m_q[m_q.size() - i];
            if (b != m_pat[3'(i)]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_pat = 8'h0A;
        m_len = 4;
        m_q.delete();
        m_cnt = 0;
        m_cnt_s = 0;
        m_flag_q = 1'b0;
        m_err = 1'b0;
    endfunction

    // One clock of stimulus; samples flag mid-cycle and advances the model at the edge.
    task automatic drive(input logic d, input logic v, input logic we,
                         input logic [7:0] p, input logic [3:0] l, input logic clr);
        logic legal;
        @(negedge clk);
        din = d; din_valid = v; cfg_we = we; cfg_pattern = p; cfg_len = l;
        cnt_clr = clr; overlap_en = ov_r;
        #1;
        obs_flag   = flag;
        obs_flag_s = flag_s;
        exp_flag   = v && !we && model_hit(d);
        legal      = (l != 4'd0) && (l <= 4'd8);
        @(posedge clk);
        m_flag_q = exp_flag;
        m_err    = we && !legal;
        if (we) begin
            if (legal) begin
                m_pat = p;
                m_len = 32'(l);
                m_q.delete();
            end
        end else if (v) begin
            if (exp_flag && !ov_r) begin
                m_q.delete();
            end else begin
                m_q.push_back(d);
                if (m_q.size() > MAX_W) void'(m_q.pop_front());
            end
        end
        if (clr) begin
            m_cnt   = exp_flag ? 1 : 0;
            m_cnt_s = exp_flag ? 1 : 0;
        end else if (exp_flag) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
        end
        #1;
    endtask

    task automatic send(input logic d, input logic v);
        drive(d, v, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l);
        drive(1'b0, 1'b0, 1'b1, p, l, 1'b0);
    endtask

    // Asserts reset with a would-be matching bit presented, then releases it.
    task automatic do_reset();
        @(negedge clk);
        din = 1'b0; din_valid = 1'b1; cfg_we = 1'b0; cnt_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        obs_flag = flag;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        din_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
        do_reset();
        checks++; if (obs_flag !== 1'b0) begin failures++; $display("FAIL reset_flag: got %b expected 0", obs_flag); end
        checks++; if (flag_q !== 1'b0) begin failures++; $display("FAIL reset_flag_q: got %b expected 0", flag_q); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
    endtask

    task automatic test_overlap(input logic ov, input logic [5:0] exp_flags, input int exp_cnt);
        logic [5:0] stream;
        stream = 6'b101010;
        do_reset();
        ov_r = ov;
        for (int i = 5; i >= 0; i--) begin
            send(stream[i], 1'b1);
            checks++;
            if (obs_flag !== exp_flags[i]) begin
                failures++;
                $display("FAIL overlap%0b_flag bit%0d: got %b expected %b", ov, 6 - i, obs_flag, exp_flags[i]);
            end
        end
        checks++;
        if (match_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL overlap%0b_cnt: got %0d expected %0d", ov, match_cnt, exp_cnt); end
        ov_r = 1'b1;
    endtask

    task automatic test_kmp();
        logic [3:0] stream, exp_flags;
        stream = 4'b1110;
        exp_flags = 4'b0001;
        do_reset();
        load(8'b0000_0110, 4'd3);
        for (int i = 3; i >= 0; i--) begin
            send(stream[i], 1'b1);
            checks++;
            if (obs_flag !== exp_flags[i]) begin
                failures++;
                $display("FAIL kmp_flag bit%0d: got %b expected %b", 4 - i, obs_flag, exp_flags[i]);
            end
        end
    endtask

    task automatic test_gap();
        do_reset();
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0);
            checks++; if (obs_flag !== 1'b0) begin failures++; $display("FAIL gap_idle_flag: got %b expected 0", obs_flag); end
        end
        send(1'b0, 1'b1);
        checks++; if (obs_flag !== 1'b1) begin failures++; $display("FAIL gap_flag: got %b expected 1", obs_flag); end
        checks++; if (flag_q !== 1'b1) begin failures++; $display("FAIL gap_flag_q: got %b expected 1", flag_q); end
        send(1'b0, 1'b0);
        checks++; if (flag_q !== 1'b0) begin failures++; $display("FAIL gap_flag_q_fall: got %b expected 0", flag_q); end
    endtask

    task automatic test_cfg_err();
        do_reset();
        load(8'hFF, 4'd0);
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_pulse: got %b expected 1", cfg_err); end
        send(1'b0, 1'b0);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_clear: got %b expected 0", cfg_err); end
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 8'hFF, 4'd9, 1'b0);
        checks++; if (obs_flag !== 1'b0) begin failures++; $display("FAIL cfg_drop_flag: got %b expected 0", obs_flag); end
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_len9: got %b expected 1", cfg_err); end
        send(1'b0, 1'b1);
        checks++; if (obs_flag !== 1'b1) begin failures++; $display("FAIL cfg_keep_pattern: got %b expected 1", obs_flag); end
        checks++; if (match_cnt !== 8'd1) begin failures++; $display("FAIL cfg_cnt: got %0d expected 1", match_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        load(8'h01, 4'd1);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b1);
            checks++; if (obs_flag !== 1'b1) begin failures++; $display("FAIL sat_flag %0d: got %b expected 1", i, obs_flag); end
        end
        checks++; if (match_cnt_s !== 2'd3) begin failures++; $display("FAIL sat_cnt2: got %0d expected 3", match_cnt_s); end
        checks++; if (match_cnt !== 8'd5) begin failures++; $display("FAIL sat_cnt8: got %0d expected 5", match_cnt); end
        drive(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
        checks++; if (match_cnt_s !== 2'd1) begin failures++; $display("FAIL clr_on_match: got %0d expected 1", match_cnt_s); end
        drive(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
        checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL clr_alone: got %0d expected 0", match_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load(8'h06, 4'd3);
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
        do_reset();
        checks++; if (obs_flag !== 1'b0) begin failures++; $display("FAIL midrst_in_reset: got %b expected 0", obs_flag); end
        send(1'b0, 1'b1);
        checks++; if (obs_flag !== 1'b0) begin failures++; $display("FAIL midrst_flag: got %b expected 0", obs_flag); end
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1); send(1'b0, 1'b1);
        checks++; if (obs_flag !== 1'b1) begin failures++; $display("FAIL midrst_default: got %b expected 1", obs_flag); end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0) ov_r = ~ov_r;
            if (r < 3) begin
                drive(1'($urandom), 1'($urandom), 1'b1, 8'($urandom),
                      4'($urandom_range(0, 9)), 1'($urandom_range(0, 3) == 0));
            end else if (r < 6) begin
                load(8'($urandom), 4'($urandom_range(1, 4)));
            end else begin
                drive(1'($urandom), 1'($urandom_range(0, 4) != 0), 1'b0, 8'h00, 4'd0,
                      1'($urandom_range(0, 29) == 0));
            end
            checks++; if (obs_flag !== exp_flag) begin failures++; $display("FAIL rnd_flag n=%0d: got %b expected %b", n, obs_flag, exp_flag); end
            checks++; if (obs_flag_s !== exp_flag) begin failures++; $display("FAIL rnd_flag_s n=%0d: got %b expected %b", n, obs_flag_s, exp_flag); end
            checks++; if (flag_q !== m_flag_q || flag_q_s !== m_flag_q) begin failures++; $display("FAIL rnd_flag_q n=%0d: got %b/%b expected %b", n, flag_q, flag_q_s, m_flag_q); end
            checks++; if (cfg_err !== m_err || cfg_err_s !== m_err) begin failures++; $display("FAIL rnd_cfg_err n=%0d: got %b/%b expected %b", n, cfg_err, cfg_err_s, m_err); end
            checks++; if (match_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL rnd_cnt n=%0d: got %0d expected %0d", n, match_cnt, m_cnt); end
            checks++; if (match_cnt_s !== 2'(m_cnt_s)) begin failures++; $display("FAIL rnd_cnt_s n=%0d: got %0d expected %0d", n, match_cnt_s, m_cnt_s); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overlap(1'b1, 6'b000101, 2);
        test_overlap(1'b0, 6'b000100, 1);
        test_kmp();
        test_gap();
        test_cfg_err();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
